// File: rtl/macc_dot_sched.sv
// Round-robin dot-product scheduler sharing one external 8x8 MAC between two requesters.
// Optional operand-stall watchdog: define MACC_SCHED_WDOG_EN.
`timescale 1ns/1ps
module macc_dot_sched #(
    parameter int LEN_W = 8
`ifdef MACC_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYC = 16
`endif
) (
    input  logic               Clk,
    input  logic               aclr,
    input  logic [1:0]         req_valid,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [1:0]         req_ready,
    input  logic [15:0]        op_a,
    input  logic [15:0]        op_b,
    input  logic [1:0]         op_valid,
    output logic [1:0]         op_ready,
    output logic [7:0]         mac_dataa,
    output logic [7:0]         mac_datab,
    output logic               mac_clken,
    output logic               mac_sload,
    input  logic [15:0]        mac_adder_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [15:0]        res_data,
    output logic               res_id,
    output logic               res_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             r_id;
    logic             r_first;
    logic             r_zero;
    logic [LEN_W-1:0] r_cnt;

    logic             w_grant;
    logic             w_win;
    logic [LEN_W-1:0] w_len;
    logic             w_opv;
    logic [7:0]       w_a;
    logic [7:0]       w_b;
    logic             w_last;

    logic [1:0]       w_req_ready;
    logic [1:0]       w_op_ready;
    logic [7:0]       w_dataa;
    logic [7:0]       w_datab;
    logic             w_clken;
    logic             w_sload;
    logic             w_res_valid;
    logic [15:0]      w_res_data;
    logic             w_res_id;

`ifdef MACC_SCHED_WDOG_EN
    localparam int SW = $clog2(WDOG_CYC + 1);
    logic [SW-1:0] r_stall;
    logic          r_err;
    logic          w_abort;
    assign w_abort = !w_opv && (r_stall == SW'(WDOG_CYC - 1));
`endif

    // r_prio names the requester that wins a tie
    assign w_grant = |req_valid;
    assign w_win   = (&req_valid) ? r_prio : req_valid[1];
    assign w_len   = w_win ? req_len[2*LEN_W-1:LEN_W]
                           : req_len[LEN_W-1:0];
    assign w_opv   = r_id ? op_valid[1] : op_valid[0];
    assign w_a     = r_id ? op_a[15:8] : op_a[7:0];
    assign w_b     = r_id ? op_b[15:8] : op_b[7:0];
    assign w_last  = (r_cnt == LEN_W'(1));

    always_ff @(posedge Clk or posedge aclr) begin
        if (aclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_op_ready  = 2'b00;
        w_dataa     = 8'd0;
        w_datab     = 8'd0;
        w_clken     = 1'b0;
        w_sload     = 1'b0;
        w_res_valid = 1'b0;
        w_res_data  = 16'd0;
        w_res_id    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_req_ready[w_win] = 1'b1;
                    w_state_nxt = (w_len == '0) ? S_RESULT : S_STREAM;
                end
            end
            S_STREAM: begin
                w_op_ready[r_id] = 1'b1;
                if (w_opv) begin
                    w_clken = 1'b1;
                    w_dataa = w_a;
                    w_datab = w_b;
                    w_sload = r_first;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end
`ifdef MACC_SCHED_WDOG_EN
                end else if (w_abort) begin
                    w_state_nxt = S_RESULT;
`endif
                end
            end
            // zero operands push the last product through the MAC input stage
            S_DRAIN: begin
                w_clken     = 1'b1;
                w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                w_res_valid = 1'b1;
                w_res_data  = r_zero ? 16'd0 : mac_adder_out;
                w_res_id    = r_id;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge aclr) begin
        if (aclr) begin
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_first <= 1'b0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
`ifdef MACC_SCHED_WDOG_EN
            r_stall <= '0;
            r_err   <= 1'b0;
`endif
        end else if (r_state == S_IDLE && w_grant) begin
            r_id    <= w_win;
            r_prio  <= ~w_win;
            r_cnt   <= w_len;
            r_first <= 1'b1;
            r_zero  <= (w_len == '0);
`ifdef MACC_SCHED_WDOG_EN
            r_stall <= '0;
            r_err   <= 1'b0;
`endif
        end else if (r_state == S_STREAM) begin
            if (w_opv) begin
                r_first <= 1'b0;
                r_cnt   <= r_cnt - 1'b1;
`ifdef MACC_SCHED_WDOG_EN
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
                if (w_abort) begin
                    r_zero <= 1'b1;
                    r_err  <= 1'b1;
                end
`endif
            end
        end
    end

    // combinational grant is masked so every output is 0 while reset is held
    assign req_ready = w_req_ready & {2{~aclr}};
    assign op_ready  = w_op_ready;
    assign mac_dataa = w_dataa;
    assign mac_datab = w_datab;
    assign mac_clken = w_clken;
    assign mac_sload = w_sload;
    assign res_valid = w_res_valid;
    assign res_data  = w_res_data;
    assign res_id    = w_res_id;
`ifdef MACC_SCHED_WDOG_EN
    assign res_err   = w_res_valid & r_err;
`else
    assign res_err   = 1'b0;
`endif

endmodule

// File: doc/macc_dot_sched.md
# macc_dot_sched

Job scheduler that shares one external approximate 8x8 unsigned multiply-accumulate unit between two requesters. It arbitrates dot-product jobs round-robin and streams the winner's operand pairs into the MAC. It drives the MAC's clken/sload sequencing, including the pipeline drain, and returns the 16-bit accumulated result with the requester ID. It sits between the two operand producers and the MAC instance in the functional-unit cluster.

## Interface
- LEN_W, 8, width of job length (elements per dot product)
- WDOG_CYC, 16, operand-stall cycles before abort (used only with the watchdog macro)

- Clk  in  1  clock
- aclr  in  1  reset, asynchronous, active-high
- req_valid  in  2  job request per requester (bit i = requester i)
- req_len  in  2*LEN_W  job length per requester; [LEN_W*i +: LEN_W]
- req_ready  out  2  job accepted (one-hot, one cycle)
- op_a, op_b  in  16 each  operand byte per requester; [8*i +: 8]
- op_valid  in  2  operand pair valid per requester
- op_ready  out  2  operand pair consumed (one-hot)
- mac_dataa, mac_datab  out  8 each  to MAC dataa/datab
- mac_clken, mac_sload  out  1 each  to MAC clken/sload
- mac_adder_out  in  16  from MAC adder_out
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  16  dot-product result
- res_id  out  1  requester that owned the job
- res_err  out  1  job aborted by watchdog (constant 0 without the macro)

## Operation
- States: IDLE, STREAM, DRAIN, RESULT.
- IDLE:
  - Winner = the requester with req_valid set. If both are set, the winner is the one not granted last; prio_ptr resets to requester 0.
  - Assert req_ready[winner] combinationally. Latch id and len at the edge, and toggle prio_ptr to the loser.
  - len==0 goes to RESULT with a zero result. Otherwise go to STREAM with first=1.
- STREAM:
  - op_ready[id]=1, other bit 0.
  - On op_valid[id]: mac_clken=1, mac_dataa/datab = the requester's bytes, mac_sload=first. Then clear first and decrement the count.
  - The last element goes to DRAIN.
  - If op_valid[id]=0: mac_clken=0, mac_dataa/datab/sload = 0, and the MAC holds.
- DRAIN: one cycle with mac_clken=1, dataa=datab=0, sload=0. This flushes the MAC's input register into adder_out. Go to RESULT.
- RESULT:
  - res_valid=1, mac_clken=0 (MAC frozen).
  - res_data = mac_adder_out, or 0 for a zero/aborted job.
  - Hold until res_ready, then go to IDLE.
- The MAC does its own approximate lower-bit accumulation and 16-bit wrap. The scheduler passes its value through unmodified.
- Outside the states above, every output is 0.
- Reset: state=IDLE, prio_ptr=0, all outputs 0. Reset mid-job discards the job with no result. The next job's sload clears the MAC.

## Timing
- No-stall job of N elements, handshake in cycle 0:
  - elements presented in cycles 1..N
  - DRAIN in cycle N+1
  - res_valid from cycle N+2
- Each stall cycle adds one cycle.
- len==0: res_valid in cycle 1.
- Minimum IDLE occupancy between jobs is 1 cycle. The result handshake and the next job's req_ready never share a cycle.
- req_valid may arrive in any state and is ignored until IDLE.
- op_valid of the non-owner is ignored; its op_ready stays 0.
- op_ready[id] is asserted for the whole of STREAM. A transfer occurs only in a cycle with op_valid[id]=1.

## Configuration
- MACC_SCHED_WDOG_EN defined:
  - A stall counter counts consecutive STREAM cycles with op_valid[id]=0 and clears on any transfer.
  - When it reaches WDOG_CYC, go to RESULT with res_data=0, res_err=1. DRAIN is skipped.
- Undefined: no counter, STREAM waits indefinitely, res_err tied 0.

## Test plan
- Reset, then req 0 with len=2, pairs (1,2),(1,4), no stalls -> req_ready=01 in cycle 0; mac_sload=1 only in cycle 1; DRAIN in cycle 3; res_valid in cycle 4 with res_data=6, res_id=0.
- Both requesters request at once after reset: req 0 len=1 (16,1), req 1 len=1 (32,1) -> req 0 served first, result 16 id 0; then req 1, result 32 id 1.
- Req 1 len=3 pairs (16,1),(32,1),(1,1) with 2 idle op_valid cycles after the first pair -> mac_clken=0 in those cycles; res_data=49 at cycle 7.
- len=0 request -> res_valid next cycle, res_data=0, mac_clken never asserted; res_ready held low 5 cycles -> result held stable.
- aclr pulsed in STREAM mid-job -> all outputs 0 immediately; a new len=1 job (3,5) returns 15, not corrupted by the old partial sum.
- With MACC_SCHED_WDOG_EN, WDOG_CYC=16: stall 16 cycles after the first element -> res_valid with res_err=1, res_data=0. A 15-cycle stall completes normally.
